// File: rtl/proc_scheduler.sv
// Time-multiplexes NPROC processors onto one outbound bus. One processor owns the bus at a time;
// switches go through a one-cycle handoff, and a watchdog plus fatal/bad-target checks latch a sticky error.
module proc_scheduler_lane #(
  parameter int BUS_W = 50,
  parameter int ID    = 0
) (
  input  logic             i_run,
  input  logic [2:0]       i_active,
  input  logic [BUS_W-1:0] i_bus,
  input  logic             i_req,
  input  logic [2:0]       i_tgt,
  input  logic             i_fatal,
  input  logic             i_hb,
  output logic             o_en,
  output logic [BUS_W-1:0] o_bus,
  output logic             o_req,
  output logic [2:0]       o_tgt,
  output logic             o_fatal,
  output logic             o_hb
);
  // Each lane zeroes its contribution unless it is the running owner, so the top can OR-reduce.
  assign o_en    = i_run && (i_active == 3'(ID));
  assign o_bus   = o_en ? i_bus : '0;
  assign o_req   = o_en & i_req;
  assign o_tgt   = o_en ? i_tgt : 3'd0;
  assign o_fatal = o_en & i_fatal;
  assign o_hb    = o_en & i_hb;
endmodule

module proc_scheduler #(
  parameter int NPROC     = 4,
  parameter int BUS_W     = 50,
  parameter int BOOT_ID   = 0,
  parameter int WDT_W     = 24,
  parameter int WDT_LIMIT = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NPROC-1:0]       p_switch_req,
  input  logic [NPROC*3-1:0]     p_switch_target,
  input  logic [NPROC-1:0]       p_fatal,
  input  logic [NPROC-1:0]       p_heartbeat,
  input  logic [NPROC*BUS_W-1:0] p_bus,
  input  logic                   err_clr,
  output logic [NPROC-1:0]       p_enable,
  output logic [BUS_W-1:0]       bus_out,
  output logic [2:0]             active_id,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [2:0]             err_id
);
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HANDOFF, S_ERROR} state_t;

  localparam logic [WDT_W-1:0] WDT_LAST = (WDT_LIMIT > 0) ? WDT_W'(WDT_LIMIT - 1) : '0;
  localparam logic [3:0]       NPROC_L  = 4'(NPROC);
  localparam logic [2:0]       BOOT_L   = 3'(BOOT_ID);

  state_t           r_state, w_next;
  logic [2:0]       r_active, r_pending, r_err_id;
  logic [1:0]       r_err_code, w_code;
  logic             r_error;
  logic [WDT_W-1:0] r_wdt;

  logic                        w_run;
  logic [NPROC-1:0][BUS_W-1:0] w_lane_bus;
  logic [NPROC-1:0][2:0]       w_lane_tgt;
  logic [NPROC-1:0]            w_lane_req, w_lane_fatal, w_lane_hb;
  logic [BUS_W-1:0]            w_bus;
  logic [2:0]                  w_tgt;
  logic                        w_req, w_fatal, w_hb, w_bad, w_wdt_exp;

  assign w_run = (r_state == S_RUN);

  for (genvar gi = 0; gi < NPROC; gi++) begin : g_lane
    proc_scheduler_lane #(.BUS_W(BUS_W), .ID(gi)) u_lane (
      .i_run   (w_run),
      .i_active(r_active),
      .i_bus   (p_bus[gi*BUS_W +: BUS_W]),
      .i_req   (p_switch_req[gi]),
      .i_tgt   (p_switch_target[gi*3 +: 3]),
      .i_fatal (p_fatal[gi]),
      .i_hb    (p_heartbeat[gi]),
      .o_en    (p_enable[gi]),
      .o_bus   (w_lane_bus[gi]),
      .o_req   (w_lane_req[gi]),
      .o_tgt   (w_lane_tgt[gi]),
      .o_fatal (w_lane_fatal[gi]),
      .o_hb    (w_lane_hb[gi])
    );
  end

  always_comb begin
    w_bus = '0;
    w_tgt = 3'd0;
    for (int i = 0; i < NPROC; i++) begin
      w_bus = w_bus | w_lane_bus[i];
      w_tgt = w_tgt | w_lane_tgt[i];
    end
  end

  assign w_req     = |w_lane_req;
  assign w_fatal   = |w_lane_fatal;
  assign w_hb      = |w_lane_hb;
  assign w_bad     = w_req && ({1'b0, w_tgt} >= NPROC_L);
  assign w_wdt_exp = (WDT_LIMIT != 0) && !w_hb && (r_wdt >= WDT_LAST);

  always_comb begin
    w_next = r_state;
    w_code = 2'b00;
    case (r_state)
      S_BOOT:    w_next = S_RUN;
      S_RUN: begin
        if (w_fatal)        begin w_next = S_ERROR; w_code = 2'b01; end
        else if (w_bad)     begin w_next = S_ERROR; w_code = 2'b10; end
        else if (w_wdt_exp) begin w_next = S_ERROR; w_code = 2'b11; end
        else if (w_req)     w_next = S_HANDOFF;
      end
      S_HANDOFF: w_next = S_RUN;
      S_ERROR:   if (err_clr) w_next = S_BOOT;
      default:   w_next = S_BOOT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_BOOT;
      r_active   <= BOOT_L;
      r_pending  <= 3'd0;
      r_wdt      <= '0;
      r_error    <= 1'b0;
      r_err_code <= 2'b00;
      r_err_id   <= 3'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_BOOT: begin
          r_active <= BOOT_L;
          r_wdt    <= '0;
        end
        S_RUN: begin
          if (w_next == S_ERROR) begin
            r_error    <= 1'b1;
            r_err_code <= w_code;
            r_err_id   <= r_active;
          end else if (w_next == S_HANDOFF) begin
            r_pending <= w_tgt;
          end else if (w_hb) begin
            r_wdt <= '0;
          end else if (r_wdt != '1) begin
            r_wdt <= r_wdt + WDT_W'(1);
          end
        end
        S_HANDOFF: begin
          r_active <= r_pending;
          r_wdt    <= '0;
        end
        S_ERROR: begin
          if (err_clr) begin
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
            r_err_id   <= 3'd0;
            r_active   <= BOOT_L;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_out   = w_bus;
  assign active_id = r_active;
  assign error     = r_error;
  assign err_code  = r_err_code;
  assign err_id    = r_err_id;
endmodule
